seq_det_serializer: RTL
=======================

SEQ_DET_SERIALIZER -- requirements
Module: seq_det_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits; SHALL be >= 2.
REQ-002 Parameter: MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: load_data  input  WIDTH  parallel word to be serialized.
REQ-006 Port: load_valid  input  1  load_data is valid this cycle.
REQ-007 Port: load_ready  output  1  block can accept a word this cycle; combinational, equals NOT hold_full.
REQ-008 Port: serout  output  1  registered serial bit stream for the downstream serial-input sequence detector.
REQ-009 Port: ser_valid  output  1  registered; high while serout carries a data bit.
REQ-010 Port: ser_last  output  1  registered; high while serout carries the final bit of a word.
REQ-011 Port: busy  output  1  equals ser_valid OR hold_full.

Function
REQ-012 Storage: the block SHALL contain one WIDTH-bit holding register with a hold_full flag, a WIDTH-bit shift register and a bit counter sized ceil(log2(WIDTH)).
REQ-013 Accept: a word is accepted on a rising edge where load_valid=1 and load_ready=1; load_data is ignored at all other times.
REQ-014 FSM states: IDLE (shifter empty, ser_valid=0) and SHIFT (ser_valid=1).
REQ-015 IDLE + accept: the word SHALL bypass the holding register into the shifter; first bit on serout in the cycle after the accepting edge; bit_cnt=0; next state SHIFT.
REQ-016 IDLE + hold_full: a condition unreachable by design; if entered, the held word SHALL move to the shifter on the next edge and hold_full SHALL clear.
REQ-017 SHIFT: each edge SHALL advance one bit in MSB_FIRST order and increment bit_cnt; exactly WIDTH bits per word, none dropped or repeated.
REQ-018 SHIFT + accept while not on the last bit: the word SHALL go to the holding register and hold_full SHALL be set.
REQ-019 ser_last SHALL be 1 exactly when bit_cnt = WIDTH-1 in SHIFT.
REQ-020 Last-bit edge, hold_full=1: the held word SHALL load into the shifter, hold_full SHALL clear, bit_cnt=0 and the state SHALL stay SHIFT.
REQ-021 Last-bit edge, hold_full=0, accept: the new word SHALL bypass into the shifter, giving a gap-free stream.
REQ-022 Last-bit edge, no pending word: the next state SHALL be IDLE.
REQ-023 Throughput: continuous load_valid SHALL produce a contiguous bit stream with ser_valid held high and no idle bit between words.
REQ-024 Idle level: serout SHALL be 0 whenever ser_valid=0, so downstream sees no spurious 1s.
REQ-025 Simultaneous drain and fill: load_ready derives from registered hold_full, so a word is never accepted into the holding register on the same edge it drains.

Reset
REQ-026 While rst=1, and immediately on assertion: state=IDLE, serout=0, ser_valid=0, ser_last=0, hold_full=0, bit_cnt=0, busy=0.
REQ-027 load_ready SHALL read 1 during reset, but no word SHALL be accepted while rst=1.
REQ-028 Reset mid-word SHALL discard both the in-flight word and the held word; the first edge after deassertion with load_valid=1 SHALL start a fresh word at bit 0.

Verification
REQ-029 Reset: assert rst asynchronously mid-cycle -> serout=0, ser_valid=0, ser_last=0, busy=0, load_ready=1 without waiting for a clock edge.
REQ-030 Single word, WIDTH=8, MSB_FIRST=1, load_data=8'b1011_0011 -> serout sequence 1,0,1,1,0,0,1,1 on 8 consecutive cycles starting the cycle after accept; ser_last only on the 8th; then serout=0, ser_valid=0.
REQ-031 Back-to-back: 8'hA5 then 8'h3C with load_valid held high -> 16 contiguous valid bits 1010_0101_0011_1100; ser_last on bits 8 and 16; load_ready=0 while the second word waits in the holding register.
REQ-032 MSB_FIRST=0, load_data=8'h01 -> serout=1 on first bit, 0 on remaining 7; ser_last on 8th.
REQ-033 Reset mid-word: 8'hFF accepted and a second word held, rst pulsed after 3 bits -> outputs 0 immediately, held word lost; after release, 8'h80 -> serout 1 then seven 0s.
REQ-034 Stall: load_valid=0 for 5 cycles between two words -> ser_valid=0 and serout=0 during the gap; the second word starts cleanly at bit 0.

Source files
------------

// File: rtl/seq_det_serializer.sv
// seq_det_serializer
//   Turns parallel words into a serial bit stream for a downstream
//   serial-input sequence detector. The block has one holding register, so
//   a second word can be queued while the current word shifts out. With
//   load_valid held high, the words come out back to back with no idle bit
//   between them.
//
//   State table
//     state | meaning
//     IDLE  | shifter empty, ser_valid=0, serout=0
//     SHIFT | shifter driving one data bit per cycle on serout
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_data   parallel word to serialize (WIDTH bits)
//   load_valid  load_data is valid this cycle
//   load_ready  a word can be accepted this cycle (= !hold_full)
//   serout      registered serial data, 0 when no bit is valid
//   ser_valid   registered, high while serout carries a data bit
//   ser_last    registered, high on the final bit of each word
//   busy        ser_valid | hold_full
module seq_det_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serout,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
    logic             hold_full, hold_full_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             serout_nxt, ser_last_nxt;
    logic             accept, on_last;

    // The bit on serout always sits at the outgoing end of the shifter.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // load_ready comes only from the registered hold_full. A word that
    // drains out of the holding register on an edge therefore cannot be
    // replaced by a new word on that same edge.
    assign load_ready = ~hold_full;
    assign accept     = load_valid & load_ready;
    assign on_last    = (bit_cnt == LAST_CNT);
    assign ser_valid  = (state == SHIFT);
    assign busy       = ser_valid | hold_full;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        hold_reg_nxt  = hold_reg;
        hold_full_nxt = hold_full;
        bit_cnt_nxt   = bit_cnt;

        case (state)
            IDLE: begin
                // hold_full cannot be set in IDLE during normal operation.
                // If it ever is, the held word is sent out next.
                if (hold_full) begin
                    shreg_nxt     = hold_reg;
                    hold_full_nxt = 1'b0;
                    bit_cnt_nxt   = '0;
                    state_nxt     = SHIFT;
                end else if (accept) begin
                    shreg_nxt   = load_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (!on_last) begin
                    shreg_nxt   = advance(shreg);
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (accept) begin
                        hold_reg_nxt  = load_data;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    shreg_nxt     = hold_reg;
                    hold_full_nxt = 1'b0;
                    bit_cnt_nxt   = '0;
                end else if (accept) begin
                    shreg_nxt   = load_data;
                    bit_cnt_nxt = '0;
                end else begin
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The output flops are loaded from next-state values, so serout and
        // ser_last line up with ser_valid in the same cycle.
        serout_nxt   = (state_nxt == SHIFT) ? out_bit(shreg_nxt) : 1'b0;
        ser_last_nxt = (state_nxt == SHIFT) && (bit_cnt_nxt == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            serout    <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            hold_reg  <= hold_reg_nxt;
            hold_full <= hold_full_nxt;
            bit_cnt   <= bit_cnt_nxt;
            serout    <= serout_nxt;
            ser_last  <= ser_last_nxt;
        end
    end

endmodule
